// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller.
// Contents: FSM state enum, opcode constants, ALUOp, ALUControl and ImmSrc encodings,
// and the ImmSrc decode helper. This package has no ports.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ERROR    = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW    = 7'd3;
  localparam logic [6:0] OP_SW    = 7'd35;
  localparam logic [6:0] OP_RTYPE = 7'd51;
  localparam logic [6:0] OP_ITYPE = 7'd19;
  localparam logic [6:0] OP_BEQ   = 7'd99;
  localparam logic [6:0] OP_JAL   = 7'd111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format is a pure function of the opcode, independent of state.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp plus instruction fields to ALUControl.
// Ports:
//   alu_op      - 2-bit operation class from the main FSM
//   funct3      - instruction funct3
//   op_bit5     - opcode bit 5 (1 for R-type, 0 for I-type ALU ops)
//   funct7_bit5 - instruction bit 30
//   alu_control - 3-bit ALU function select
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op_bit5,
  input  logic       funct7_bit5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type with bit 30 set subtracts; addi never does.
          3'b000:  alu_control = (op_bit5 && funct7_bit5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle controller for a shared instruction/data memory datapath.
// Ports:
//   clk, rst               - rising-edge clock, asynchronous active-high reset
//   op, funct3, funct7_bit5- instruction fields from the instruction register
//   Zero                   - ALU zero flag (branch condition)
//   MemReady               - memory completes the current access this cycle
//   instret_wr/_wdata      - synchronous load of the retired-instruction counter
//   MemReq .. ImmSrc       - datapath controls
//   InstrDone              - one-cycle retire pulse
//   Halt                   - illegal opcode seen, held until reset
//   InstRet                - retired-instruction count (wraps)
//   state_dbg              - current FSM state
//
// Memory handshake: MemReq is a request held high for the whole access; the
// access completes on the cycle MemReq=1 and MemReady=1 are both high. MemReq
// depends only on the state, so it never combinationally follows MemReady, and
// MemReady is ignored whenever MemReq is low.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7_bit5,
  input  logic        Zero,
  input  logic        MemReady,
  input  logic        instret_wr,
  input  logic [31:0] instret_wdata,
  output logic        MemReq,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic        InstrDone,
  output logic        Halt,
  output logic [31:0] InstRet,
  output state_t      state_dbg
);

  state_t      state_q, state_d;
  logic [1:0]  alu_op;
  logic [31:0] inst_ret_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_ERROR;
        endcase
      end
      // op is stable from the instruction register; anything else here is corrupt.
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMREAD;
        else if (op == OP_SW) state_d = S_MEMWRITE;
        else                  state_d = S_ERROR;
      end
      S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (MemReady) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;  // ALUWB writes rd = PC+4
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_ERROR;
    endcase
  end

  // Output logic
  always_comb begin
    MemReq    = 1'b0;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = ALUOP_ADD;
    InstrDone = 1'b0;
    Halt      = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        // Instruction latch and PC+4 both happen on the completing cycle.
        IRWrite   = MemReady;
        PCWrite   = MemReady;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_MEMWRITE: begin
        MemReq    = 1'b1;
        AdrSrc    = 1'b1;
        MemWrite  = 1'b1;
        InstrDone = MemReady;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA   = 2'b10;
        alu_op    = ALUOP_SUB;
        PCWrite   = Zero;
        InstrDone = 1'b1;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_ERROR: Halt = 1'b1;
      default: Halt = 1'b1;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op_bit5     (op[5]),
    .funct7_bit5 (funct7_bit5),
    .alu_control (ALUControl)
  );

  // Retired-instruction counter; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             inst_ret_q <= '0;
    else if (instret_wr) inst_ret_q <= instret_wdata;
    else if (InstrDone)  inst_ret_q <= inst_ret_q + 32'd1;
  end

  assign ImmSrc    = imm_src_of(op);
  assign InstRet   = inst_ret_q;
  assign state_dbg = state_q;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port op  input  7  instruction opcode field, from the instruction register.
REQ-004 SHALL have port funct3  input  3  instruction funct3 field.
REQ-005 SHALL have port funct7_bit5  input  1  instruction bit 30.
REQ-006 SHALL have port Zero  input  1  ALU zero flag.
REQ-007 SHALL have port MemReady  input  1  memory completes the current access this cycle.
REQ-008 SHALL have outputs MemReq(1), PCWrite(1), AdrSrc(1), MemWrite(1), IRWrite(1), RegWrite(1), ResultSrc(2), ALUSrcA(2), ALUSrcB(2), ALUControl(3) and ImmSrc(2), all datapath controls.
REQ-009 SHALL have outputs InstrDone  1  one-cycle retire pulse; Halt  1  illegal opcode seen; InstRet  32  retired-instruction count.

Function
REQ-010 SHALL sequence a shared instruction/data memory datapath using states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL and ERROR.
REQ-011 SHALL drive every control not listed for a state to 0.
REQ-012 FETCH: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=PCWrite=MemReady; holds until MemReady=1, then goes to DECODE.
REQ-013 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00; next state is MEMADR for op 3 or 35, EXECR for 51, EXECI for 19, BEQ for 99, JAL for 111, and ERROR for any other op.
REQ-014 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; next state is MEMREAD for op 3 and MEMWRITE for op 35.
REQ-015 MEMREAD: MemReq=1, AdrSrc=1, ResultSrc=00; holds until MemReady=1, then goes to MEMWB.
REQ-016 MEMWB: ResultSrc=01, RegWrite=1; next state FETCH.
REQ-017 MEMWRITE: MemReq=1, AdrSrc=1, MemWrite=1; holds until MemReady=1, then goes to FETCH; the memory commits the write on the MemReady cycle.
REQ-018 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10; next state ALUWB.
REQ-019 EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; next state ALUWB.
REQ-020 ALUWB: ResultSrc=00, RegWrite=1; next state FETCH.
REQ-021 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero; next state FETCH.
REQ-022 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1; next state ALUWB, which writes rd=PC+4.
REQ-023 ERROR: Halt=1, all strobes 0; state is held until reset.
REQ-024 ImmSrc SHALL decode from op in every state: 35->01, 99->10, 111->11, otherwise 00.
REQ-025 ALUControl SHALL decode combinationally as follows.
- ALUOp 00 -> 000.
- ALUOp 01 -> 001.
- ALUOp 10, funct3 000 -> 001 (sub) only when {op[5],funct7_bit5}=11, else 000.
- ALUOp 10, funct3 010 -> 101.
- ALUOp 10, funct3 110 -> 011.
- ALUOp 10, funct3 111 -> 010.
- Anything else -> 000.
REQ-026 InstrDone SHALL pulse for exactly one cycle on the cycle the state leaves MEMWB, ALUWB or BEQ, or leaves MEMWRITE with MemReady=1.
REQ-027 InstRet SHALL increment on each InstrDone and wrap from FFFFFFFF to 00000000.
REQ-028 Worst-case latency SHALL be: lw 5 cycles; sw 4; R/I 4; beq 3; jal 4; plus one cycle per MemReady=0 wait.
REQ-029 MemReady SHALL be ignored in all states except FETCH, MEMREAD and MEMWRITE.

Reset
REQ-030 Asserting rst SHALL immediately force state FETCH, InstRet=0, InstrDone=0 and Halt=0, including mid-access and from ERROR.
REQ-031 On the first clock edge after rst deasserts, the block SHALL already be in FETCH with MemReq=1.

Structure
REQ-032 A shared package SHALL hold the state enum, the opcode constants (3, 35, 51, 19, 99, 111), the ALUControl encodings and the ImmSrc encodings.
REQ-033 The ALU decoder SHALL be a combinational sub-module, alu_decoder; the main FSM, outputs and counter stay in multicycle_controller.

Verification
REQ-034 The bench SHALL cover: add (op 51, f3 000, f7b5 0), MemReady=1 -> states FETCH, DECODE, EXECR, ALUWB; ALUControl=000; RegWrite in cycle 4; InstRet=1.
REQ-035 The bench SHALL cover: lw (op 3) with MemReady=0 for 2 cycles in MEMREAD -> MEMREAD held 3 cycles; MemReq=1 throughout; RegWrite only in MEMWB; total 7 cycles.
REQ-036 The bench SHALL cover: beq (op 99) with Zero=1 -> PCWrite=1 in BEQ; with Zero=0 -> PCWrite=0; in both cases ALUControl=001 and InstrDone pulses.
REQ-037 The bench SHALL cover: op 0x7F -> ERROR, Halt=1 and all strobes 0 for 10 cycles; then rst -> FETCH, Halt=0.
REQ-038 The bench SHALL cover: rst asserted during MEMWRITE wait -> MemWrite drops asynchronously and the state is FETCH; with InstRet preloaded to FFFFFFFF, one retire -> 00000000.
